// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store; 2-cycle minimum latency, +1 per wait state.
// Backpressure: requests stay held until their valid pulse; the stall outputs tell the hazard unit to freeze the stage.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_valid_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_f_o,
  output logic                stall_m_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic               mem_req_q, mem_req_d;
  logic               if_valid_q, if_valid_d;
  logic               dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic if_elig, dm_elig, starved, grant_if, grant_dm;

  // A requester whose valid is high this cycle is still holding the old request.
  assign if_elig  = if_req_i & ~if_valid_q;
  assign dm_elig  = dm_req_i & ~dm_valid_q;
  assign starved  = (cnt_q == CNT_W'(STARVE_LIMIT));
  assign grant_if = if_elig & (~dm_elig | starved);
  assign grant_dm = dm_elig & ~grant_if;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    mem_req_d  = mem_req_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          cmd_d.we    = 1'b0;
          cmd_d.addr  = if_addr_i;
          cmd_d.wdata = '0;
          cmd_d.be    = '1;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY_IF;
        end else if (grant_dm) begin
          cmd_d.we    = dm_we_i;
          cmd_d.addr  = dm_addr_i;
          cmd_d.wdata = dm_wdata_i;
          cmd_d.be    = dm_be_i;
          mem_req_d   = 1'b1;
          state_d     = BUSY_DM;
          if (if_elig && !starved) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready_i) begin
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata_i;
          state_d    = IDLE;
        end
      end
      BUSY_DM: begin
        if (mem_ready_i) begin
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          if (!cmd_q.we) begin
            dm_rdata_d = mem_rdata_i;
          end
          state_d    = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      mem_req_q  <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      mem_req_q  <= mem_req_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign mem_be_o    = cmd_q.be;
  assign if_valid_o  = if_valid_q;
  assign dm_valid_o  = dm_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_f_o   = if_req_i & ~if_valid_q;
  assign stall_m_o   = dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk, rst_n;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [3:0]  dm_be_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o, stall_f_o, stall_m_o;
  logic [3:0]  mem_be_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_f_o(stall_f_o), .stall_m_o(stall_m_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: answers after wait_states idle cycles of an active request.
  int wait_states = 0;
  bit force_ready = 1'b0;
  int wcnt = 0;
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = BAD;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_o) begin
        if (wcnt >= wait_states) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = rd_fn(mem_addr_o);
          wcnt = 0;
        end else begin
          mem_ready_i = 1'b0;
          mem_rdata_i = BAD;
          wcnt++;
        end
      end else begin
        mem_ready_i = force_ready;
        mem_rdata_i = BAD;
        wcnt = 0;
      end
    end
  end

  // Reference model: who owns the port, the command in flight, and the starvation tally.
  int          m_owner;  // 0 = nobody, 1 = fetch, 2 = data
  int          m_cnt;
  logic        m_req, m_we, m_ifv, m_dmv;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
  logic [3:0]  m_be;
  logic        m_ife, m_dme;
  assign m_ife = if_req_i && !m_ifv;
  assign m_dme = dm_req_i && !m_dmv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_cnt <= 0; m_req <= 1'b0; m_we <= 1'b0; m_addr <= '0;
      m_wdata <= '0; m_be <= '0; m_ifv <= 1'b0; m_dmv <= 1'b0; m_ifr <= '0; m_dmr <= '0;
    end else begin
      m_ifv <= 1'b0;
      m_dmv <= 1'b0;
      if (m_owner != 0) begin
        if (mem_ready_i) begin
          if (m_owner == 1) begin
            m_ifv <= 1'b1;
            m_ifr <= mem_rdata_i;
          end else begin
            m_dmv <= 1'b1;
            if (!m_we) m_dmr <= mem_rdata_i;
          end
          m_owner <= 0;
          m_req   <= 1'b0;
        end
      end else if (m_ife && (!m_dme || m_cnt == STARVE)) begin
        m_owner <= 1; m_req <= 1'b1; m_we <= 1'b0; m_addr <= if_addr_i;
        m_wdata <= '0; m_be <= 4'hF; m_cnt <= 0;
      end else if (m_dme) begin
        m_owner <= 2; m_req <= 1'b1; m_we <= dm_we_i; m_addr <= dm_addr_i;
        m_wdata <= dm_wdata_i; m_be <= dm_be_i;
        if (m_ife && m_cnt < STARVE) m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req",   mem_req_o,   m_req);
    chk("mem_we",    mem_we_o,    m_we);
    chk("mem_addr",  mem_addr_o,  m_addr);
    chk("mem_wdata", mem_wdata_o, m_wdata);
    chk("mem_be",    mem_be_o,    m_be);
    chk("if_valid",  if_valid_o,  m_ifv);
    chk("dm_valid",  dm_valid_o,  m_dmv);
    chk("if_rdata",  if_rdata_o,  m_ifr);
    chk("dm_rdata",  dm_rdata_o,  m_dmr);
    chk("stall_f",   stall_f_o,   if_req_i && !m_ifv);
    chk("stall_m",   stall_m_o,   dm_req_i && !m_dmv);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input bit is_if, input int budget, output int n);
    n = 0;
    while (!(is_if ? if_valid_o : dm_valid_o) && n < budget) begin
      tick();
      n++;
    end
  endtask

  byte  obs[$];
  string want_seq = "DDDDIDDDDDI";
  logic [31:0] a0, w0;
  logic [3:0]  b0;
  bit   prev;
  int   n;

  initial begin
    rst_n = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
    repeat (3) tick();
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_if_valid", if_valid_o, 1'b0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single fetch, zero-wait memory.
    wait_states = 0;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1 chk("f1_stall_c0", stall_f_o, 1'b1);
    tick();
    chk("f1_mem_req_c1", mem_req_o, 1'b1);
    chk("f1_mem_addr_c1", mem_addr_o, 32'h100);
    chk("f1_mem_we_c1", mem_we_o, 1'b0);
    chk("f1_mem_be_c1", mem_be_o, 4'hF);
    chk("f1_stall_c1", stall_f_o, 1'b1);
    tick();
    chk("f1_if_valid_c2", if_valid_o, 1'b1);
    chk("f1_if_rdata_c2", if_rdata_o, 32'h0050_0093);
    chk("f1_stall_c2", stall_f_o, 1'b0);
    if_req_i = 1'b0;
    repeat (2) tick();

    // Loads: second one is held through the first's valid cycle.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000;
    tick();
    chk("ld_mem_addr_c1", mem_addr_o, 32'h3000);
    tick();
    chk("ld_dm_valid_c2", dm_valid_o, 1'b1);
    chk("ld_dm_rdata_c2", dm_rdata_o, 32'h3000_CFFF);
    chk("ld_mem_req_c2", mem_req_o, 1'b0);
    dm_addr_i = 32'h3004;
    tick();
    chk("ld_mem_req_c3", mem_req_o, 1'b0);
    tick();
    chk("ld_mem_req_c4", mem_req_o, 1'b1);
    chk("ld_mem_addr_c4", mem_addr_o, 32'h3004);
    tick();
    chk("ld_dm_valid_c5", dm_valid_o, 1'b1);
    chk("ld_dm_rdata_c5", dm_rdata_o, 32'h3004_CFFB);
    dm_req_i = 1'b0;
    tick();
    chk("ld_no_dup_req", mem_req_o, 1'b0);

    // Store with three wait states.
    wait_states = 3;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h2000;
    dm_wdata_i = 32'hDEAD_BEEF; dm_be_i = 4'h3;
    tick();
    a0 = mem_addr_o; w0 = mem_wdata_o; b0 = mem_be_o;
    chk("st_mem_we", mem_we_o, 1'b1);
    chk("st_mem_addr", a0, 32'h2000);
    chk("st_mem_wdata", w0, 32'hDEAD_BEEF);
    chk("st_mem_be", b0, 4'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_req", mem_req_o, 1'b1);
      chk("st_hold_cmd", {mem_addr_o, mem_wdata_o}, {32'h2000, 32'hDEAD_BEEF});
      chk("st_no_early_valid", dm_valid_o, 1'b0);
    end
    tick();
    chk("st_dm_valid", dm_valid_o, 1'b1);
    chk("st_dm_rdata_kept", dm_rdata_o, 32'h3004_CFFB);
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    tick();
    chk("st_single_pulse", dm_valid_o, 1'b0);

    // Contention: fetch raised at every DM grant, dropped in each DM valid cycle.
    wait_states = 0;
    if_addr_i = 32'h400; dm_addr_i = 32'h5000; dm_be_i = 4'hF;
    dm_req_i = 1'b1; if_req_i = 1'b1;
    prev = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      tick();
      if (mem_req_o && !prev) obs.push_back((mem_addr_o == 32'h400) ? "I" : "D");
      prev = mem_req_o;
      if (obs.size() >= 11) break;
      if_req_i = !dm_valid_o;
    end
    chk("cont_grant_count", obs.size(), 11);
    foreach (obs[i]) chk("cont_grant_seq", obs[i], want_seq[i]);
    dm_req_i = 1'b0;
    wait_valid(1'b1, 20, n);
    chk("cont_last_if_valid", if_valid_o, 1'b1);
    if_req_i = 1'b0;
    tick();

    // mem_ready in IDLE with no request is ignored.
    force_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_rdy_req", mem_req_o, 1'b0);
      chk("idle_rdy_valid", {if_valid_o, dm_valid_o}, 2'b00);
    end
    force_ready = 1'b0;
    wait_states = 1;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    wait_valid(1'b1, 20, n);
    chk("fetch_1wait_latency", n, 3);
    if_req_i = 1'b0;
    tick();

    // Reset while a load is waiting on memory.
    wait_states = 5;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h6000;
    tick();
    chk("rst_busy_req", mem_req_o, 1'b1);
    tick();
    rst_n = 1'b0;
    #1 chk("rst_drop_req", mem_req_o, 1'b0);
    tick();
    chk("rst_no_valid", dm_valid_o, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_regrant_req", mem_req_o, 1'b1);
    chk("rst_regrant_addr", mem_addr_o, 32'h6000);
    wait_valid(1'b0, 30, n);
    chk("rst_regrant_latency", n, 6);
    chk("rst_regrant_rdata", dm_rdata_o, 32'h6000_9FFF);
    dm_req_i = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
